// File: rtl/train_seq_pkg.sv
// Shared types for the multicycle train sequencer.
// State enum, layer-count limit and one-hot decode helper.
package train_seq_pkg;

    localparam int MAX_LAYERS = 8;
    localparam int IDX_W      = 3;

    typedef enum logic [2:0] {
        IDLE,
        FWD_GO,
        FWD_WAIT,
        BP_GO,
        BP_WAIT,
        COMMIT,
        DONE,
        ERROR
    } state_e;

    function automatic logic [MAX_LAYERS-1:0] onehot(
        input logic [IDX_W-1:0] idx
    );
        logic [MAX_LAYERS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/train_seq_watchdog.sv
// Per-layer wait watchdog for the train sequencer.
// Ports: clock, reset_n, clear, enable in; first (count is 0), expired out.
module train_seq_watchdog #(
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic first,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Count 0 marks the first wait cycle, where a stale done is ignored.
    assign first   = (cnt_q == '0);
    assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_train_sequencer.sv
// N-layer forward/backprop sequencer with mini-batch weight commit.
// Ports: start/train/abort/layer_done in; per-layer start/commit vectors,
// acc_clear, busy, done, error, err_layer, sample_cnt out (all registered).
module multicycle_train_sequencer
    import train_seq_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int MINIBATCH  = 1,
    parameter int DONE_HOLD  = 3,
    parameter int TIMEOUT    = 4096,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  train,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [NUM_LAYERS-1:0] layer_fwd_start,
    output logic [NUM_LAYERS-1:0] layer_bp_start,
    output logic [NUM_LAYERS-1:0] weight_wr,
    output logic                  acc_clear,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            err_layer,
    output logic [7:0]            sample_cnt
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LAYERS - 1);
    localparam logic [7:0] BATCH_END = 8'(MINIBATCH - 1);
    localparam int HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(DONE_HOLD - 1);

    state_e state_q, state_d;

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  train_q, train_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [7:0]            cnt_d;
    logic [2:0]            err_d;
    logic                  acc_d;
    logic [NUM_LAYERS-1:0] fwd_d, bp_d, wr_d;
    logic                  wd_clear, wd_en, wd_first, wd_expired;
    logic [MAX_LAYERS-1:0] done_vec, oh;
    logic                  hit;
    logic                  unused_oh;

    train_seq_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wd (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .enable  (wd_en),
        .first   (wd_first),
        .expired (wd_expired)
    );

    assign done_vec  = MAX_LAYERS'(layer_done);
    assign hit       = !wd_first && done_vec[idx_q];
    assign oh        = onehot(idx_d);
    assign unused_oh = ^oh;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        train_d  = train_q;
        cnt_d    = sample_cnt;
        err_d    = err_layer;
        hold_d   = '0;
        acc_d    = 1'b0;
        wd_clear = 1'b0;
        wd_en    = 1'b0;

        // Abort outranks everything, including a same-cycle layer_done.
        if (abort && state_q != IDLE && state_q != ERROR) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, ERROR: begin
                    if (start) begin
                        state_d = FWD_GO;
                        idx_d   = '0;
                        train_d = train;
                        acc_d   = train && (sample_cnt == '0);
                    end
                end
                FWD_GO: begin
                    wd_clear = 1'b1;
                    state_d  = FWD_WAIT;
                end
                FWD_WAIT: begin
                    wd_en = 1'b1;
                    if (hit) begin
                        if (idx_q != LAST) begin
                            idx_d   = idx_q + 1'b1;
                            state_d = FWD_GO;
                        end else if (train_q) begin
                            idx_d   = LAST;
                            state_d = BP_GO;
                        end else begin
                            state_d = DONE;
                        end
                    end else if (wd_expired) begin
                        err_d   = idx_q;
                        state_d = ERROR;
                    end
                end
                BP_GO: begin
                    wd_clear = 1'b1;
                    state_d  = BP_WAIT;
                end
                BP_WAIT: begin
                    wd_en = 1'b1;
                    if (hit) begin
                        if (idx_q != '0) begin
                            idx_d   = idx_q - 1'b1;
                            state_d = BP_GO;
                        end else begin
                            state_d = COMMIT;
                        end
                    end else if (wd_expired) begin
                        err_d   = idx_q;
                        state_d = ERROR;
                    end
                end
                COMMIT: begin
                    cnt_d   = (sample_cnt == BATCH_END) ? 8'd0
                                                        : sample_cnt + 8'd1;
                    state_d = DONE;
                end
                DONE: begin
                    hold_d = hold_q + 1'b1;
                    if (hold_q == HOLD_END) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they register cleanly.
        fwd_d = '0;
        bp_d  = '0;
        wr_d  = '0;
        if (state_d == FWD_GO) fwd_d = oh[NUM_LAYERS-1:0];
        if (state_d == BP_GO)  bp_d  = oh[NUM_LAYERS-1:0];
        if (state_d == COMMIT && sample_cnt == BATCH_END) wr_d = '1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q           <= '0;
            train_q         <= 1'b0;
            hold_q          <= '0;
            sample_cnt      <= '0;
            err_layer       <= '0;
            acc_clear       <= 1'b0;
            layer_fwd_start <= '0;
            layer_bp_start  <= '0;
            weight_wr       <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            idx_q           <= idx_d;
            train_q         <= train_d;
            hold_q          <= hold_d;
            sample_cnt      <= cnt_d;
            err_layer       <= err_d;
            acc_clear       <= acc_d;
            layer_fwd_start <= fwd_d;
            layer_bp_start  <= bp_d;
            weight_wr       <= wr_d;
            busy            <= (state_d != IDLE) && (state_d != ERROR);
            done            <= (state_d == DONE);
            error           <= (state_d == ERROR);
        end
    end

endmodule

// File: tb/tb_multicycle_train_sequencer.sv
// Self-checking bench for multicycle_train_sequencer.
// Layer responders return done after a chosen delay; a sample model checks.
module tb_multicycle_train_sequencer;

    localparam int NL = 3;
    localparam int MB = 4;
    localparam int DH = 3;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          train = 1'b0;
    logic          abort = 1'b0;
    logic [NL-1:0] layer_done = '0;
    logic [NL-1:0] layer_fwd_start, layer_bp_start, weight_wr;
    logic          acc_clear, busy, done, error;
    logic [2:0]    err_layer;
    logic [7:0]    sample_cnt;

    always #5 clock = ~clock;

    multicycle_train_sequencer #(
        .NUM_LAYERS (NL),
        .MINIBATCH  (MB),
        .DONE_HOLD  (DH),
        .TIMEOUT    (TO),
        .CNT_W      (8)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .train           (train),
        .abort           (abort),
        .layer_done      (layer_done),
        .layer_fwd_start (layer_fwd_start),
        .layer_bp_start  (layer_bp_start),
        .weight_wr       (weight_wr),
        .acc_clear       (acc_clear),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .err_layer       (err_layer),
        .sample_cnt      (sample_cnt)
    );

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int cd[NL];
    int fixed_k = 0;
    int stall = -1;
    int pos = 0;
    int fwd_code, bp_code, ww_cnt, ww_bad, acc_cnt, done_cyc, oh_viol;

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int first_idx(input logic [NL-1:0] v);
        for (int i = 0; i < NL; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Start order encoded base 8, each entry as layer+1.
    function automatic int order_code(input bit up);
        int c = 0;
        for (int i = 0; i < NL; i++) c = c * 8 + (up ? i : NL - 1 - i) + 1;
        return c;
    endfunction

    function automatic int outs_packed();
        return int'({busy, done, error, acc_clear, weight_wr,
                     layer_fwd_start, layer_bp_start, err_layer,
                     sample_cnt});
    endfunction

    task automatic clear_logs();
        fwd_code = 0; bp_code = 0; ww_cnt = 0; ww_bad = 0;
        acc_cnt = 0; done_cyc = 0; oh_viol = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (layer_fwd_start != '0)
            fwd_code = fwd_code * 8 + first_idx(layer_fwd_start) + 1;
        if (layer_bp_start != '0)
            bp_code = bp_code * 8 + first_idx(layer_bp_start) + 1;
        if ($countones({layer_fwd_start, layer_bp_start}) > 1) oh_viol++;
        if (weight_wr != '0) begin
            ww_cnt++;
            if (weight_wr != '1) ww_bad++;
        end
        acc_cnt  += int'(acc_clear);
        done_cyc += int'(done);
        layer_done = '0;
        for (int i = 0; i < NL; i++) begin
            if (cd[i] > 0) begin
                cd[i]--;
                if (cd[i] == 0) begin
                    layer_done[i] = 1'b1;
                    cd[i] = -1;
                end
            end
            if ((layer_fwd_start[i] && i != stall) || layer_bp_start[i])
                cd[i] = (fixed_k > 0 ? fixed_k
                                     : int'($urandom_range(9, 3))) - 1;
        end
    endtask

    task automatic run_sample(input logic tr, input int k, input string tag);
        int  e_acc, e_ww, nobusy;
        bit  seen, fin;
        clear_logs();
        fixed_k = k;
        seen = 0; fin = 0; nobusy = 0;
        e_acc = (tr && pos == 0) ? 1 : 0;
        e_ww  = (tr && pos == MB - 1) ? 1 : 0;
        start = 1'b1;
        train = tr;
        tick();
        start = 1'b0;
        train = 1'($urandom);
        chk({tag, ".err_clr"}, int'(error), 0);
        for (int n = 0; n < 300; n++) begin
            if (done) seen = 1;
            if (seen && !done) begin
                fin = 1;
                break;
            end
            if (!busy) nobusy++;
            tick();
        end
        if (tr) pos = (pos + 1) % MB;
        chk({tag, ".finished"}, int'(fin), 1);
        chk({tag, ".busy"}, nobusy, 0);
        chk({tag, ".fwd_order"}, fwd_code, order_code(1));
        chk({tag, ".bp_order"}, bp_code, tr ? order_code(0) : 0);
        chk({tag, ".weight_wr"}, ww_cnt, e_ww);
        chk({tag, ".ww_value"}, ww_bad, 0);
        chk({tag, ".acc_clear"}, acc_cnt, e_acc);
        chk({tag, ".done_len"}, done_cyc, DH);
        chk({tag, ".sample_cnt"}, int'(sample_cnt), pos);
        chk({tag, ".onehot"}, oh_viol, 0);
        fixed_k = 0;
    endtask

    initial begin
        int p, e, p0;
        bit found;
        for (int i = 0; i < NL; i++) cd[i] = -1;
        clear_logs();

        repeat (2) tick();
        chk("reset.outs", outs_packed(), 0);
        reset_n = 1'b1;
        tick();
        chk("reset.idle", outs_packed(), 0);

        run_sample(1'b1, 5, "train5");
        run_sample(1'b0, 5, "infer1");
        run_sample(1'b0, 0, "infer2");
        run_sample(1'b1, 0, "batch2");
        run_sample(1'b1, 0, "batch3");
        run_sample(1'b1, 0, "batch4");
        for (int s = 0; s < 8; s++) run_sample(1'($urandom), 0, "rand");

        // Layer 1 never answers its forward start.
        clear_logs();
        stall = 1;
        p0 = pos;
        start = 1'b1;
        train = 1'b1;
        tick();
        start = 1'b0;
        p = -1000;
        e = -1;
        for (int n = 0; n < 100; n++) begin
            if (layer_fwd_start[1] && p < 0) p = cyc;
            if (error) begin
                e = cyc;
                break;
            end
            tick();
        end
        chk("timeout.latency", e - p, TO + 1);
        chk("timeout.err_layer", int'(err_layer), 1);
        chk("timeout.busy", int'(busy), 0);
        chk("timeout.weight_wr", ww_cnt, 0);
        chk("timeout.done", done_cyc, 0);
        chk("timeout.sample_cnt", int'(sample_cnt), p0);
        repeat (4) tick();
        chk("timeout.sticky", int'(error), 1);
        stall = -1;
        run_sample(1'b1, 0, "after_to");

        // Abort lands in the same cycle as layer 1's backprop done.
        clear_logs();
        fixed_k = 5;
        p0 = pos;
        start = 1'b1;
        train = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int n = 0; n < 200; n++) begin
            if (layer_bp_start[1]) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("abort.reach_bp1", int'(found), 1);
        repeat (4) tick();
        chk("abort.same_cycle_done", int'(layer_done[1]), 1);
        clear_logs();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort.idle", int'(busy), 0);
        repeat (30) tick();
        chk("abort.no_bp0", bp_code, 0);
        chk("abort.no_ww", ww_cnt, 0);
        chk("abort.no_done", done_cyc, 0);
        chk("abort.sample_cnt", int'(sample_cnt), p0);
        fixed_k = 0;

        // Asynchronous reset in the middle of a forward wait.
        start = 1'b1;
        train = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (layer_fwd_start[1]) break;
            tick();
        end
        tick();
        tick();
        chk("areset.busy_before", int'(busy), 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("areset.outs", outs_packed(), 0);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < NL; i++) cd[i] = -1;
        layer_done = '0;
        pos = 0;
        tick();
        chk("areset.idle", int'(busy), 0);
        run_sample(1'b1, 0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
